// File: rtl/evt_irq_latch.sv
// Multi-channel rising-edge event latch with per-channel ack/mask, saturating
// missed-event counters and a registered fixed-priority interrupt request.
module evt_irq_latch #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_CH-1:0]         i_evt,
  input  logic [N_CH-1:0]         i_ack,
  input  logic [N_CH-1:0]         i_mask,
  input  logic [N_CH-1:0]         i_cnt_clr,
  output logic [N_CH-1:0]         o_pending,
  output logic                    o_irq,
  output logic [ID_W-1:0]         o_irq_id,
  output logic [N_CH*CNT_W-1:0]   o_miss_cnt
);

  localparam logic [CNT_W-1:0] MISS_MAX = '1;

  logic [N_CH-1:0]             prev_q;
  logic [N_CH-1:0]             pend_q, pend_d;
  logic [N_CH-1:0][CNT_W-1:0]  miss_q, miss_d;
  logic                        irq_q, irq_d;
  logic [ID_W-1:0]             id_q, id_d;
  logic [N_CH-1:0]             rise;
  logic [N_CH-1:0]             req;

  // Ack handshake: i_ack[i] is a one-cycle pulse that clears pend[i]; a rise
  // on the same edge wins, re-arming pending without counting a miss.
  always_comb begin
    rise   = i_evt & ~prev_q;
    pend_d = rise | (pend_q & ~i_ack);
    miss_d = miss_q;
    for (int i = 0; i < N_CH; i++) begin
      if (i_cnt_clr[i]) begin
        miss_d[i] = '0;
      end else if (rise[i] && pend_q[i] && !i_ack[i] && (miss_q[i] != MISS_MAX)) begin
        miss_d[i] = miss_q[i] + CNT_W'(1);
      end
    end
  end

  // Interrupt stage looks at registered pending, so event-to-IRQ is two edges.
  always_comb begin
    req   = pend_q & i_mask;
    irq_d = |req;
    id_d  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        id_d = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= '0;
      pend_q <= '0;
      miss_q <= '0;
      irq_q  <= 1'b0;
      id_q   <= '0;
    end else begin
      prev_q <= i_evt;
      pend_q <= pend_d;
      miss_q <= miss_d;
      irq_q  <= irq_d;
      id_q   <= id_d;
    end
  end

  assign o_pending  = pend_q;
  assign o_irq      = irq_q;
  assign o_irq_id   = id_q;
  assign o_miss_cnt = miss_q;

endmodule

// File: tb/tb_evt_irq_latch.sv
// Directed bench for evt_irq_latch: 4-channel main instance plus 32- and
// 1-channel instances for the parameter corners.
module tb_evt_irq_latch;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 4-channel instance
  logic [3:0]  evt4 = '0, ack4 = '0, mask4 = 4'b1111, clr4 = '0;
  logic [3:0]  pend4;
  logic        irq4;
  logic [1:0]  id4;
  logic [31:0] miss4;

  evt_irq_latch dut4 (
    .clk(clk), .rstn(rstn), .i_evt(evt4), .i_ack(ack4), .i_mask(mask4),
    .i_cnt_clr(clr4), .o_pending(pend4), .o_irq(irq4), .o_irq_id(id4),
    .o_miss_cnt(miss4)
  );

  // 32-channel instance
  logic [31:0]  evt32 = '0, ack32 = '0, mask32 = '1, clr32 = '0;
  logic [31:0]  pend32;
  logic         irq32;
  logic [4:0]   id32;
  logic [255:0] miss32;

  evt_irq_latch #(.N_CH(32)) dut32 (
    .clk(clk), .rstn(rstn), .i_evt(evt32), .i_ack(ack32), .i_mask(mask32),
    .i_cnt_clr(clr32), .o_pending(pend32), .o_irq(irq32), .o_irq_id(id32),
    .o_miss_cnt(miss32)
  );

  // 1-channel instance
  logic [0:0] evt1 = '0, ack1 = '0, mask1 = 1'b1, clr1 = '0;
  logic [0:0] pend1;
  logic       irq1;
  logic [0:0] id1;
  logic [7:0] miss1;

  evt_irq_latch #(.N_CH(1)) dut1 (
    .clk(clk), .rstn(rstn), .i_evt(evt1), .i_ack(ack1), .i_mask(mask1),
    .i_cnt_clr(clr1), .o_pending(pend1), .o_irq(irq1), .o_irq_id(id1),
    .o_miss_cnt(miss1)
  );

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse4(input logic [3:0] ch);
    evt4 = ch;
    tick();
    evt4 = '0;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    evt4 = 4'b0001;
    #12;
    n_vec++; if (pend4 !== 4'b0000) begin n_err++; $display("FAIL rst_pend got %b exp 0000", pend4); end
    n_vec++; if (irq4 !== 1'b0 || id4 !== 2'd0) begin n_err++; $display("FAIL rst_irq got %b/%0d exp 0/0", irq4, id4); end
    n_vec++; if (miss4 !== 32'h0) begin n_err++; $display("FAIL rst_miss got %h exp 0", miss4); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    n_vec++; if (pend4 !== 4'b0001 || irq4 !== 1'b0) begin n_err++; $display("FAIL hold_edge1 got %b/%b exp 0001/0", pend4, irq4); end
    tick();
    n_vec++; if (irq4 !== 1'b1 || id4 !== 2'd0) begin n_err++; $display("FAIL hold_edge2 got %b/%0d exp 1/0", irq4, id4); end
    tick(18);
    ack4 = 4'b0001;
    tick();
    ack4 = '0;
    n_vec++; if (pend4 !== 4'b0000) begin n_err++; $display("FAIL hold_ack got %b exp 0000", pend4); end
    tick();
    n_vec++; if (irq4 !== 1'b0) begin n_err++; $display("FAIL hold_irq_clr got %b exp 0", irq4); end
    n_vec++; if (miss4[7:0] !== 8'd0) begin n_err++; $display("FAIL hold_miss got %0d exp 0", miss4[7:0]); end
    evt4 = '0;
    tick();
  endtask

  task automatic test_priority_mask();
    mask4 = 4'b1111;
    pulse4(4'b1010);
    n_vec++; if (irq4 !== 1'b1 || id4 !== 2'd1) begin n_err++; $display("FAIL prio_id got %b/%0d exp 1/1", irq4, id4); end
    ack4 = 4'b0010;
    tick();
    ack4 = '0;
    n_vec++; if (pend4 !== 4'b1000) begin n_err++; $display("FAIL prio_ack got %b exp 1000", pend4); end
    tick();
    n_vec++; if (id4 !== 2'd3 || irq4 !== 1'b1) begin n_err++; $display("FAIL prio_next got %b/%0d exp 1/3", irq4, id4); end
    mask4 = 4'b0111;
    tick();
    n_vec++; if (irq4 !== 1'b0) begin n_err++; $display("FAIL mask_irq got %b exp 0", irq4); end
    n_vec++; if (pend4[3] !== 1'b1) begin n_err++; $display("FAIL mask_pend got %b exp 1", pend4[3]); end
    mask4 = 4'b1111;
    tick();
    n_vec++; if (irq4 !== 1'b1 || id4 !== 2'd3) begin n_err++; $display("FAIL unmask got %b/%0d exp 1/3", irq4, id4); end
    ack4 = 4'b1000;
    tick();
    ack4 = '0;
    tick();
    n_vec++; if (irq4 !== 1'b0 || pend4 !== 4'b0000) begin n_err++; $display("FAIL prio_idle got %b/%b exp 0/0000", irq4, pend4); end
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 100; p++) pulse4(4'b0100);
    n_vec++; if (miss4[23:16] !== 8'd99) begin n_err++; $display("FAIL sat_100 got %0d exp 99", miss4[23:16]); end
    for (int p = 100; p < 256; p++) pulse4(4'b0100);
    n_vec++; if (miss4[23:16] !== 8'd255) begin n_err++; $display("FAIL sat_256 got %0d exp 255", miss4[23:16]); end
    for (int p = 256; p < 300; p++) pulse4(4'b0100);
    n_vec++; if (miss4[23:16] !== 8'd255) begin n_err++; $display("FAIL sat_300 got %0d exp 255", miss4[23:16]); end
    n_vec++; if (pend4 !== 4'b0100) begin n_err++; $display("FAIL sat_pend got %b exp 0100", pend4); end
    evt4 = 4'b0100;
    clr4 = 4'b0100;
    tick();
    evt4 = '0;
    clr4 = '0;
    n_vec++; if (miss4[23:16] !== 8'd0) begin n_err++; $display("FAIL clr_win got %0d exp 0", miss4[23:16]); end
    tick();
    pulse4(4'b0100);
    n_vec++; if (miss4[23:16] !== 8'd1) begin n_err++; $display("FAIL clr_recount got %0d exp 1", miss4[23:16]); end
    ack4 = 4'b0100;
    clr4 = 4'b0100;
    tick();
    ack4 = '0;
    clr4 = '0;
    tick();
  endtask

  task automatic test_collision();
    pulse4(4'b0001);
    pulse4(4'b0001);
    n_vec++; if (miss4[7:0] !== 8'd1 || pend4[0] !== 1'b1) begin n_err++; $display("FAIL coll_setup got %0d/%b exp 1/1", miss4[7:0], pend4[0]); end
    evt4 = 4'b0001;
    ack4 = 4'b0001;
    tick();
    evt4 = '0;
    ack4 = '0;
    n_vec++; if (pend4[0] !== 1'b1) begin n_err++; $display("FAIL coll_pend got %b exp 1", pend4[0]); end
    n_vec++; if (miss4[7:0] !== 8'd1) begin n_err++; $display("FAIL coll_miss got %0d exp 1", miss4[7:0]); end
    ack4 = 4'b0001;
    tick();
    n_vec++; if (pend4 !== 4'b0000) begin n_err++; $display("FAIL coll_ack got %b exp 0000", pend4); end
    tick();
    ack4 = '0;
    n_vec++; if (pend4 !== 4'b0000 || miss4[7:0] !== 8'd1) begin n_err++; $display("FAIL idle_ack got %b/%0d exp 0000/1", pend4, miss4[7:0]); end
    tick();
  endtask

  task automatic test_async_reset();
    evt4 = 4'b1010;
    tick();
    evt4 = '0;
    tick();
    pulse4(4'b1010);
    pulse4(4'b0010);
    n_vec++; if (pend4 !== 4'b1010) begin n_err++; $display("FAIL ar_pre_pend got %b exp 1010", pend4); end
    n_vec++; if (miss4[15:8] !== 8'd2 || miss4[31:24] !== 8'd1) begin n_err++; $display("FAIL ar_pre_miss got %0d/%0d exp 2/1", miss4[15:8], miss4[31:24]); end
    #2;
    rstn = 1'b0;
    #1;
    n_vec++; if (pend4 !== 4'b0000 || irq4 !== 1'b0 || id4 !== 2'd0 || miss4 !== 32'h0) begin
      n_err++; $display("FAIL ar_during got %b/%b/%0d/%h exp all 0", pend4, irq4, id4, miss4);
    end
    #2;
    rstn = 1'b1;
    #1;
    n_vec++; if (pend4 !== 4'b0000 || irq4 !== 1'b0 || miss4 !== 32'h0) begin
      n_err++; $display("FAIL ar_after got %b/%b/%h exp all 0", pend4, irq4, miss4);
    end
    tick(2);
    n_vec++; if (pend4 !== 4'b0000 || irq4 !== 1'b0) begin n_err++; $display("FAIL ar_settle got %b/%b exp 0000/0", pend4, irq4); end
  endtask

  task automatic test_wide();
    evt32 = '1;
    tick();
    evt32 = '0;
    n_vec++; if (pend32 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL w32_pend got %h exp ffffffff", pend32); end
    tick();
    n_vec++; if (irq32 !== 1'b1 || id32 !== 5'd0) begin n_err++; $display("FAIL w32_id0 got %b/%0d exp 1/0", irq32, id32); end
    for (int j = 0; j < 31; j++) begin
      ack32 = 32'h1 << j;
      tick();
    end
    ack32 = '0;
    n_vec++; if (id32 !== 5'd30) begin n_err++; $display("FAIL w32_lag got %0d exp 30", id32); end
    tick();
    n_vec++; if (id32 !== 5'd31 || pend32 !== 32'h8000_0000) begin n_err++; $display("FAIL w32_id31 got %0d/%h exp 31/80000000", id32, pend32); end
    pulse4(4'b0000);
    evt32 = 32'h8000_0000;
    tick();
    evt32 = '0;
    n_vec++; if (miss32[255:248] !== 8'd1) begin n_err++; $display("FAIL w32_miss got %0d exp 1", miss32[255:248]); end
  endtask

  task automatic test_single();
    evt1 = 1'b1;
    tick();
    n_vec++; if (pend1 !== 1'b1 || irq1 !== 1'b0) begin n_err++; $display("FAIL n1_edge1 got %b/%b exp 1/0", pend1, irq1); end
    tick();
    evt1 = 1'b0;
    n_vec++; if (irq1 !== 1'b1 || id1 !== 1'b0) begin n_err++; $display("FAIL n1_irq got %b/%b exp 1/0", irq1, id1); end
    tick();
    evt1 = 1'b1;
    tick();
    evt1 = 1'b0;
    n_vec++; if (miss1 !== 8'd1) begin n_err++; $display("FAIL n1_miss got %0d exp 1", miss1); end
    tick();
    evt1 = 1'b1;
    ack1 = 1'b1;
    tick();
    evt1 = 1'b0;
    n_vec++; if (pend1 !== 1'b1 || miss1 !== 8'd1) begin n_err++; $display("FAIL n1_coll got %b/%0d exp 1/1", pend1, miss1); end
    tick();
    ack1 = 1'b0;
    n_vec++; if (pend1 !== 1'b0) begin n_err++; $display("FAIL n1_ack got %b exp 0", pend1); end
    tick();
    n_vec++; if (irq1 !== 1'b0) begin n_err++; $display("FAIL n1_irq_clr got %b exp 0", irq1); end
  endtask

  initial begin
    test_reset();
    test_priority_mask();
    test_saturation();
    test_collision();
    test_async_reset();
    test_wide();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/evt_irq_latch.md
# evt_irq_latch

Parametrised multi-channel event latch and interrupt request generator. It generalises the single-bit bot-update latch beside the Rojobot into N_CH independent channels. Each channel has rising-edge detection, per-channel acknowledge and mask, and a saturating missed-event counter. A registered priority encoder presents one interrupt request and channel ID to the SweRVolf GPIO/interrupt logic. It sits between event sources (rojobot `upd_sysregs`, pushbutton debouncers, timers) that are already synchronous to its clock and the core's memory-mapped IO.

## Interface
Parameters:
- `N_CH`, 4: number of event channels, 1..32.
- `CNT_W`, 8: width of each missed-event counter, 1..16.
- `ID_W`, $clog2(N_CH) (min 1): width of `o_irq_id`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `i_evt`  in  N_CH  event inputs, synchronous to `clk`, any pulse length.
- `i_ack`  in  N_CH  per-channel acknowledge, one-cycle pulse; clears pending.
- `i_mask`  in  N_CH  1 = channel may raise `o_irq`; masking never clears pending.
- `i_cnt_clr`  in  N_CH  per-channel clear of the missed-event counter.
- `o_pending`  out  N_CH  registered pending flags.
- `o_irq`  out  1  registered; 1 when any pending & mask bit is set.
- `o_irq_id`  out  ID_W  registered; index of the lowest-numbered pending & unmasked channel.
- `o_miss_cnt`  out  N_CH*CNT_W  channel i's counter at bits [i*CNT_W +: CNT_W].

## Operation
Per channel i, the following registers exist: `prev[i]`, `pend[i]` and `miss[i]`.
- **Edge:** `rise[i] = i_evt[i] & ~prev[i]`. `prev[i] <= i_evt[i]` every cycle. An input held high for many cycles produces exactly one event.
- **Pending update, in priority order:**
  - `rise` sets pending, regardless of `i_ack`. A new event wins over a simultaneous ack.
  - Otherwise `i_ack` clears pending.
  - Otherwise pending holds.
  - An ack on a non-pending channel has no effect.
- **Missed-event counter:** increments when `rise[i] & pend[i] & ~i_ack[i]`, i.e. an event arrives while the previous one is still unacknowledged.
  - Saturates at 2^CNT_W−1; never wraps.
  - `rise & pend & i_ack` in the same cycle is not a miss: the pending flag is consumed and re-set.
  - `i_cnt_clr[i]` forces 0 and wins over a simultaneous increment.
- **IRQ stage:** `o_irq <= |(pend & i_mask)`.
  - `o_irq_id <=` the lowest index j with `pend[j] & i_mask[j]`.
  - With no such channel, `o_irq_id <= 0`.
  - Fixed priority; channel 0 is highest.
- **Mask changes:** a masked channel stays pending. Unmasking it raises `o_irq` on the following cycle.

## Timing
- **Reset:** assertion (asynchronous) forces all of the following to 0 immediately, regardless of `clk`: `prev`, `pend`, `miss`, `o_irq`, `o_irq_id`, `o_pending`.
  - Reset asserted mid-operation discards all pending events and counts.
- **First cycle after reset release:** because `prev` resets to 0, an input already high produces one event on the first rising edge after `rstn` deasserts.
- **Latency, event to pending:**
  - `i_evt` low at edge k−1 and high at edge k gives `o_pending[i]=1` after edge k.
  - `o_irq`/`o_irq_id` update after edge k+1, a 2-cycle event-to-IRQ latency.
- **Latency, ack:** `i_ack` sampled at edge m gives `o_pending` clear after m and `o_irq` low (if no other channel is pending) after m+1.
- **Clear-to-rearm:** software must ack, then may see a new event 1 cycle later. An event arriving on edge m together with the ack keeps `o_pending`=1 with no miss count.
- **Counter:** `o_miss_cnt` updates on the same edge as the triggering rise. There is no combinational path from any input to any output.

## Test plan
1. **Reset and hold-high:** hold `rstn`=0, drive `i_evt`=4'b0001, release reset.
   - After the 1st edge: `o_pending`=0001.
   - After the 2nd edge: `o_irq`=1, `o_irq_id`=0.
   - Keep `i_evt` high 20 cycles, then ack once: `o_pending`=0000, `o_miss_cnt[0]`=0.
2. **Priority and mask:** pulse ch1 and ch3 in the same cycle with `i_mask`=4'b1111.
   - `o_irq_id`=1. Ack ch1: `o_irq_id`=3 one cycle later.
   - Set `i_mask`=4'b0111: `o_irq`=0 and `o_pending[3]` stays 1.
3. **Missed-event saturation:** with CNT_W=8 and ch2 never acked, apply 300 single-cycle pulses.
   - `o_miss_cnt[2]`=255.
   - Pulse `i_cnt_clr[2]` together with a rise: count=0.
4. **Ack/event collision:**
   - Ch0 pending; in one cycle apply `i_ack[0]`=1 and a rising edge: `o_pending[0]`=1, `o_miss_cnt[0]` unchanged.
   - Ack alone on idle ch0: no change.
5. **Asynchronous reset mid-operation:** with pending=1010 and counters nonzero, pulse `rstn` low between clock edges for less than one period. All outputs are 0 before the next edge.
6. **Parameter sweep:** repeat scenarios 1–4 with N_CH=1 (ID_W=1) and N_CH=32. With all 32 channels pending, `o_irq_id`=0; after acking 0..30, `o_irq_id`=31.
